ahb_inst_mem: RTL and testbench

AHB_INST_MEM -- requirements
Module: ahb_inst_mem

---
 rtl/ahb_inst_mem.sv | 157 +++++++++++++++
 tb/tb_ahb_inst_mem.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_inst_mem.sv
// AHB-Lite instruction/data memory with configurable wait states, 64-bit read
// lanes, write-to-read bypass and a two-cycle error response.
module ahb_inst_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        HSEL,
  input  logic        HTRANS,
  input  logic [63:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_wait_cnt;
  logic [AW-1:0] r_idx;
  logic          r_write;
  logic          r_size64;
  logic          r_hready;
  logic          r_hresp;
  logic [63:0]   r_hrdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_err;
  logic          w_wr_en;
  logic [AW-1:0] w_ridx;
  logic [AW-1:0] w_ridx_hi;
  logic [AW-1:0] w_widx_hi;
  logic [31:0]   w_rd_lo;
  logic [31:0]   w_rd_hi;

  assign w_accept  = HSEL & HTRANS & r_hready;
  assign w_err     = ((HSIZE != 3'd2) && (HSIZE != 3'd3)) ||
                     (HADDR[1:0] != 2'd0) ||
                     ((HSIZE == 3'd3) && HADDR[2]) ||
                     (HADDR[63:2] >= 62'(DEPTH_WORDS));
  assign w_wr_en   = (r_state == ST_DATA) && r_write && !reset;
  assign w_ridx    = HADDR[AW+1:2];
  assign w_ridx_hi = w_ridx + IDX_ONE;
  assign w_widx_hi = r_idx + IDX_ONE;

  // A read accepted on the edge a write completes must see the write's data
  always_comb begin
    w_rd_lo = r_mem[w_ridx];
    w_rd_hi = r_mem[w_ridx_hi];
    if (w_wr_en && (w_ridx == r_idx)) begin
      w_rd_lo = HWDATA[31:0];
    end else if (w_wr_en && r_size64 && (w_ridx == w_widx_hi)) begin
      w_rd_lo = HWDATA[63:32];
    end else begin
      w_rd_lo = r_mem[w_ridx];
    end
    if (w_wr_en && (w_ridx_hi == r_idx)) begin
      w_rd_hi = HWDATA[31:0];
    end else if (w_wr_en && r_size64 && (w_ridx_hi == w_widx_hi)) begin
      w_rd_hi = HWDATA[63:32];
    end else begin
      w_rd_hi = r_mem[w_ridx_hi];
    end
  end

  // Storage is not reset; writes land on the edge that completes DATA
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[r_idx] <= HWDATA[31:0];
      if (r_size64) begin
        r_mem[w_widx_hi] <= HWDATA[63:32];
      end
    end
  end

  // Transfer FSM with registered bus responses
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 3'd0;
      r_hready   <= 1'b1;
      r_hresp    <= 1'b0;
      r_hrdata   <= 64'd0;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_size64   <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_wait_cnt == 3'd1) begin
            r_state  <= ST_DATA;
            r_hready <= 1'b1;
          end
          r_wait_cnt <= r_wait_cnt - 3'd1;
        end
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 1'b1;
        end
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (w_accept) begin
            r_idx    <= w_ridx;
            r_write  <= HWRITE & ~w_err;
            r_size64 <= (HSIZE == 3'd3);
            if (w_err) begin
              r_state  <= ST_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= 1'b1;
            end else begin
              r_hresp <= 1'b0;
              if (!HWRITE) begin
                r_hrdata <= {w_rd_hi, w_rd_lo};
              end
              if (WAIT_STATES == 0) begin
                r_state  <= ST_DATA;
                r_hready <= 1'b1;
              end else begin
                r_state    <= ST_WAIT;
                r_hready   <= 1'b0;
                r_wait_cnt <= 3'(WAIT_STATES);
              end
            end
          end else begin
            r_state  <= ST_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= 1'b0;
        end
      endcase
    end
  end

  assign HRDATA    = r_hrdata;
  assign HREADYOUT = r_hready;
  assign HRESP     = r_hresp;

endmodule

// File: tb/tb_ahb_inst_mem.sv
// Directed bench: instance A runs with one wait state, instance B with none;
// both use a 16-word memory so wrap-around and range errors are easy to reach.
module tb_ahb_inst_mem;

  localparam int DEPTH = 16;
  localparam logic [31:0] W0 = 32'h0000_0013;
  localparam logic [31:0] W1 = 32'h0010_0093;
  localparam logic [31:0] W2 = 32'h0020_0113;
  localparam logic [31:0] W3 = 32'h0030_0193;

  logic CLK;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        a_rst, a_sel, a_trans, a_write, a_ready, a_resp;
  logic [2:0]  a_size;
  logic [63:0] a_addr, a_wdata, a_rdata;
  logic        b_rst, b_sel, b_trans, b_write, b_ready, b_resp;
  logic [2:0]  b_size;
  logic [63:0] b_addr, b_wdata, b_rdata;

  logic [63:0] rd;
  logic        rsp;
  int          waits;

  ahb_inst_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut_a (
    .CLK(CLK), .reset(a_rst), .HSEL(a_sel), .HTRANS(a_trans), .HADDR(a_addr),
    .HWRITE(a_write), .HSIZE(a_size), .HWDATA(a_wdata), .HRDATA(a_rdata),
    .HREADYOUT(a_ready), .HRESP(a_resp)
  );

  ahb_inst_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_b (
    .CLK(CLK), .reset(b_rst), .HSEL(b_sel), .HTRANS(b_trans), .HADDR(b_addr),
    .HWRITE(b_write), .HSIZE(b_size), .HWDATA(b_wdata), .HRDATA(b_rdata),
    .HREADYOUT(b_ready), .HRESP(b_resp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_drive(input logic sel, input logic trans, input logic wr,
                         input logic [2:0] sz, input logic [63:0] addr, input logic [63:0] wd);
    a_sel = sel; a_trans = trans; a_write = wr; a_size = sz; a_addr = addr; a_wdata = wd;
  endtask

  task automatic b_drive(input logic sel, input logic trans, input logic wr,
                         input logic [2:0] sz, input logic [63:0] addr, input logic [63:0] wd);
    b_sel = sel; b_trans = trans; b_write = wr; b_size = sz; b_addr = addr; b_wdata = wd;
  endtask

  // One complete transfer on A; returns data/response seen when HREADYOUT rises
  task automatic a_xfer(input logic wr, input logic [2:0] sz, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] rdo, output logic rspo,
                        output int nw);
    @(negedge CLK);
    a_drive(1'b1, 1'b1, wr, sz, addr, 64'd0);
    @(negedge CLK);
    a_drive(1'b0, 1'b0, 1'b0, 3'd2, 64'd0, wd);
    nw = 0;
    while (a_ready !== 1'b1 && nw < 20) begin
      nw++;
      @(negedge CLK);
    end
    rdo  = a_rdata;
    rspo = a_resp;
  endtask

  // Error transfer on B: two-cycle response, then back to idle
  task automatic b_err(input string tag, input logic wr, input logic [2:0] sz, input logic [63:0] addr);
    @(negedge CLK);
    b_drive(1'b1, 1'b1, wr, sz, addr, 64'd0);
    @(negedge CLK);
    chk({tag, "_err1"}, {b_ready, b_resp}, 64'd1);
    b_drive(1'b0, 1'b0, 1'b0, 3'd2, 64'd0, 64'd0);
    @(negedge CLK);
    chk({tag, "_err2"}, {b_ready, b_resp}, 64'd3);
    @(negedge CLK);
    chk({tag, "_idle"}, {b_ready, b_resp}, 64'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_drive(1'b0, 1'b0, 1'b0, 3'd2, 64'd0, 64'd0);
    b_drive(1'b0, 1'b0, 1'b0, 3'd2, 64'd0, 64'd0);
    repeat (2) @(negedge CLK);
    chk("a_rst_ready", a_ready, 64'd1);
    chk("a_rst_resp", a_resp, 64'd0);
    chk("a_rst_rdata", a_rdata, 64'd0);
    chk("b_rst_ready", b_ready, 64'd1);
    a_rst = 1'b0; b_rst = 1'b0;

    // Instance A: one wait state
    a_xfer(1'b1, 3'd3, 64'h0, {W1, W0}, rd, rsp, waits);
    chk("a_wr64_waits", 64'(waits), 64'd1);
    chk("a_wr64_resp", rsp, 64'd0);
    a_xfer(1'b0, 3'd2, 64'h0, 64'd0, rd, rsp, waits);
    chk("a_rd0_waits", 64'(waits), 64'd1);
    chk("a_rd0_data", rd, {W1, W0});
    chk("a_rd0_resp", rsp, 64'd0);

    a_xfer(1'b1, 3'd2, 64'(4 * (DEPTH - 1)), 64'h0000_0000_CAFE_F00D, rd, rsp, waits);
    a_xfer(1'b0, 3'd2, 64'(4 * (DEPTH - 1)), 64'd0, rd, rsp, waits);
    chk("a_wrap_data", rd, {W0, 32'hCAFE_F00D});

    a_xfer(1'b0, 3'd2, 64'(4 * DEPTH), 64'd0, rd, rsp, waits);
    chk("a_range_waits", 64'(waits), 64'd1);
    chk("a_range_resp", rsp, 64'd1);
    @(negedge CLK);
    chk("a_range_idle", {a_ready, a_resp}, 64'd2);

    // Reset in the middle of a write's wait state discards the write
    a_xfer(1'b1, 3'd2, 64'h20, 64'h0000_0000_1111_1111, rd, rsp, waits);
    @(negedge CLK);
    a_drive(1'b1, 1'b1, 1'b1, 3'd2, 64'h20, 64'd0);
    @(negedge CLK);
    a_drive(1'b0, 1'b0, 1'b0, 3'd2, 64'd0, 64'hBADB_AD00_BADB_AD00);
    chk("a_midwait_ready", a_ready, 64'd0);
    a_rst = 1'b1;
    @(negedge CLK);
    a_rst = 1'b0;
    chk("a_postrst_ready", a_ready, 64'd1);
    chk("a_postrst_resp", a_resp, 64'd0);
    chk("a_postrst_rdata", a_rdata, 64'd0);
    a_xfer(1'b0, 3'd2, 64'h20, 64'd0, rd, rsp, waits);
    chk("a_mem8_kept", rd[31:0], 64'h1111_1111);

    // Instance B: zero wait states, back-to-back writes then reads
    @(negedge CLK);
    b_drive(1'b1, 1'b1, 1'b1, 3'd3, 64'h0, 64'd0);
    @(negedge CLK);
    b_drive(1'b1, 1'b1, 1'b1, 3'd3, 64'h8, {W1, W0});
    @(negedge CLK);
    b_drive(1'b0, 1'b0, 1'b0, 3'd2, 64'h0, {W3, W2});
    @(negedge CLK);
    b_drive(1'b1, 1'b1, 1'b0, 3'd2, 64'h0, 64'd0);
    @(negedge CLK);
    chk("b_p0_ready", b_ready, 64'd1);
    chk("b_p0_data", b_rdata, {W1, W0});
    b_drive(1'b1, 1'b1, 1'b0, 3'd2, 64'h4, 64'd0);
    @(negedge CLK);
    chk("b_p1_ready", b_ready, 64'd1);
    chk("b_p1_data", b_rdata[31:0], W1);
    b_drive(1'b1, 1'b1, 1'b0, 3'd2, 64'h8, 64'd0);
    @(negedge CLK);
    chk("b_p2_ready", b_ready, 64'd1);
    chk("b_p2_data", b_rdata[31:0], W2);
    b_drive(1'b0, 1'b0, 1'b0, 3'd2, 64'h0, 64'd0);
    @(negedge CLK);
    chk("b_p3_idle", {b_ready, b_resp}, 64'd2);

    // Write immediately followed by a read of the same word
    b_drive(1'b1, 1'b1, 1'b1, 3'd2, 64'h10, 64'd0);
    @(negedge CLK);
    b_drive(1'b1, 1'b1, 1'b0, 3'd2, 64'h10, 64'h0000_0000_DEAD_BEEF);
    @(negedge CLK);
    chk("b_bypass_lo", b_rdata[31:0], 64'hDEAD_BEEF);
    b_drive(1'b1, 1'b1, 1'b1, 3'd3, 64'h18, 64'd0);
    @(negedge CLK);
    b_drive(1'b1, 1'b1, 1'b0, 3'd2, 64'h1C, 64'h2222_2222_1111_1111);
    @(negedge CLK);
    chk("b_bypass_hi", b_rdata[31:0], 64'h2222_2222);
    b_drive(1'b0, 1'b0, 1'b0, 3'd2, 64'h0, 64'd0);

    // Error responses; the erroring write must not touch memory
    b_err("b_misalign", 1'b0, 3'd2, 64'h2);
    b_err("b_size3_odd", 1'b0, 3'd3, 64'h4);
    b_err("b_badsize_wr", 1'b1, 3'd0, 64'h10);
    b_drive(1'b1, 1'b1, 1'b0, 3'd2, 64'h10, 64'd0);
    @(negedge CLK);
    chk("b_noerrwrite", b_rdata[31:0], 64'hDEAD_BEEF);
    b_drive(1'b0, 1'b1, 1'b0, 3'd2, 64'h0, 64'd0);
    @(negedge CLK);
    chk("b_unsel_hold", b_rdata[31:0], 64'hDEAD_BEEF);
    chk("b_unsel_ready", b_ready, 64'd1);
    b_drive(1'b0, 1'b0, 1'b0, 3'd2, 64'h0, 64'd0);
    repeat (2) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
